// File: rtl/alu_result_stage_if.sv
// Handshake bundle between the vALU result mux, the result stage and writeback.
// Optional RESULT_PARITY_EN adds out_parity to the bundle.
interface alu_result_stage_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_result;
  logic             in_carry;
  logic             in_ovf;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic             out_neg;
  logic             out_carry;
  logic             out_ovf;
`ifdef RESULT_PARITY_EN
  logic             out_parity;

  modport slave (
    input  in_valid, in_result, in_carry, in_ovf, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_neg, out_carry, out_ovf, out_parity
  );
  modport master (
    output in_valid, in_result, in_carry, in_ovf, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_neg, out_carry, out_ovf, out_parity
  );
`else
  modport slave (
    input  in_valid, in_result, in_carry, in_ovf, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_neg, out_carry, out_ovf
  );
  modport master (
    output in_valid, in_result, in_carry, in_ovf, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_neg, out_carry, out_ovf
  );
`endif
endinterface

// File: rtl/alu_result_stage.sv
// Registered vALU result stage: 2-entry skid buffer, zero/neg flags, transfer counter.
// Define RESULT_PARITY_EN to carry an even-parity bit (out_parity) with each word.
module alu_result_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_result_stage_if.slave    bus,
  output logic [CNT_W-1:0]     xfer_count
);

  typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             ovf;
    logic             zero;
    logic             neg;
`ifdef RESULT_PARITY_EN
    logic             parity;
`endif
  } entry_t;

  state_t           state_reg, state_next;
  entry_t           main_reg, main_next;
  entry_t           skid_reg, skid_next;
  entry_t           cap;
  logic             in_ready_reg;
  logic [CNT_W-1:0] xfer_count_reg;
  logic             accept;
  logic             send;

  // Flags come from the mux output, so they are ready the same cycle the word lands.
  always_comb begin
    cap        = '0;
    cap.result = bus.in_result;
    cap.carry  = bus.in_carry;
    cap.ovf    = bus.in_ovf;
    cap.zero   = (bus.in_result == '0);
    cap.neg    = bus.in_result[WIDTH-1];
`ifdef RESULT_PARITY_EN
    cap.parity = ^bus.in_result;
`endif
  end

  assign accept = bus.in_valid & in_ready_reg;
  assign send   = (state_reg != EMPTY) & bus.out_ready;

  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    skid_next  = skid_reg;
    case (state_reg)
      EMPTY: begin
        if (accept) begin
          main_next  = cap;
          state_next = FULL;
        end
      end
      FULL: begin
        if (send && accept) begin
          main_next = cap;
        end else if (send) begin
          state_next = EMPTY;
        end else if (accept) begin
          skid_next  = cap;
          state_next = SKID;
        end
      end
      SKID: begin
        // in_ready is low here, so upstream holds its word until we drain.
        if (send) begin
          main_next  = skid_reg;
          state_next = FULL;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= EMPTY;
      main_reg       <= '0;
      skid_reg       <= '0;
      in_ready_reg   <= 1'b1;
      xfer_count_reg <= '0;
    end else begin
      state_reg      <= state_next;
      main_reg       <= main_next;
      skid_reg       <= skid_next;
      in_ready_reg   <= (state_next != SKID);
      if (send) begin
        xfer_count_reg <= xfer_count_reg + 1'b1;
      end
    end
  end

  assign bus.in_ready   = in_ready_reg;
  assign bus.out_valid  = (state_reg != EMPTY);
  assign bus.out_result = main_reg.result;
  assign bus.out_zero   = main_reg.zero;
  assign bus.out_neg    = main_reg.neg;
  assign bus.out_carry  = main_reg.carry;
  assign bus.out_ovf    = main_reg.ovf;
`ifdef RESULT_PARITY_EN
  assign bus.out_parity = main_reg.parity;
`endif
  assign xfer_count     = xfer_count_reg;

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
Registered output stage directly downstream of the 32-bit 2:1 result-select mux in the vALU datapath. Captures the selected ALU result and its carry/overflow, derives zero/negative flags, and presents them to the consumer (register-file writeback) through a valid/ready handshake. A 2-entry skid buffer gives full throughput with a registered in_ready.

Parameters:
WIDTH, 32, datapath width of the result word
CNT_W, 16, width of the output-transfer counter

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  upstream result valid
in_ready  output  1  stage can accept; registered, not combinational from out_ready
in_result  input  WIDTH  result word from the 2:1 select mux
in_carry  input  1  carry-out of the selected operation
in_ovf  input  1  signed overflow of the selected operation
out_valid  output  1  out_result and flags valid
out_ready  input  1  consumer accepts this cycle
out_result  output  WIDTH  registered result
out_zero  output  1  out_result == 0
out_neg  output  1  out_result[WIDTH-1]
out_carry  output  1  captured carry
out_ovf  output  1  captured overflow
xfer_count  output  CNT_W  number of completed output transfers, wraps modulo 2^CNT_W

Behaviour:
- Clock/reset: single clock clk; reset synchronous, active-high, sampled on the rising edge of clk.
- accept = in_valid & in_ready; send = out_valid & out_ready.
- Storage: main entry (drives outputs), skid entry (holds one overflow word). Each entry holds {result, carry, ovf, zero, neg}. zero/neg are computed from in_result at capture, not from the registered copy.
- States: EMPTY (main invalid), FULL (main valid, skid invalid), SKID (both valid).
- EMPTY: in_ready=1, out_valid=0. accept -> load main, go FULL.
- FULL: in_ready=1, out_valid=1.
  - send & accept -> load main with new input, stay FULL.
  - send only -> EMPTY.
  - accept only -> load skid, go SKID.
  - neither -> hold.
- SKID: in_ready=0, out_valid=1.
  - send -> main <= skid, go FULL.
  - else hold.
  - in_valid is ignored; upstream must hold its data.
- in_ready is a flop equal to (next state != SKID).
- Latency: 1 cycle from accept in EMPTY to out_valid. Sustained 1 word/cycle when out_ready is held high.
- Outputs are stable while out_valid=1 and out_ready=0; no change until send.
- xfer_count increments by 1 on every send; wraps from 2^CNT_W-1 to 0.
- Reset values: state EMPTY, out_valid=0, in_ready=1, out_result=0, all flags=0, xfer_count=0, skid contents=0.
- Reset asserted mid-operation discards both entries; accept and send in that cycle have no effect.
- Order is strictly FIFO; no word is dropped or duplicated.

Optional Feature:
RESULT_PARITY_EN
- Defined: adds output out_parity (1 bit), the even parity (XOR reduction) of in_result computed at capture and carried through the main and skid entries with the word. Reset value 0.
- Undefined: port and storage are absent; all other behaviour is identical.

Test Plan:
- Reset, then in_valid=1, in_result=32'h0000_0000, out_ready=1 -> next cycle out_valid=1, out_zero=1, out_neg=0; xfer_count=1 one cycle later.
- Stream 8 words 1..8, in_valid and out_ready held high -> out_result is 1..8 on consecutive cycles, in_ready stays 1, xfer_count=8.
- Send A=32'h8000_0001 then B=32'h5 with out_ready=0 -> state SKID, in_ready=0, out_result=A, out_neg=1. Raise out_ready -> A, then B, in order; in_ready returns to 1 the cycle after A is sent.
- Assert reset while in SKID with A/B held -> next cycle out_valid=0, in_ready=1, xfer_count=0; A and B never appear.
- Hold xfer_count at 16'hFFFF and perform one send -> xfer_count=0.
- With RESULT_PARITY_EN defined, send 32'h0000_0007 -> out_parity=1; send 32'h0000_0003 -> out_parity=0.
